// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the multi-digit counter.
package cnt_pkg;

  // Every digit is stored in one nibble regardless of the radix.
  localparam int DIGIT_W = 4;

  // mode_i encodings: wrap around at terminal count, or stick there.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Limit a loaded nibble to the largest legal digit.
  // Nibbles at or above the radix then never reach the count.
  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] v,
    input logic [DIGIT_W-1:0] max_v
  );
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/cnt_ndigits_if.sv
// Control and status bundle of cnt_ndigits, used by benches and integrators
// to carry the counter's handshake signals as one object.
interface cnt_ndigits_if #(
  parameter int digits_p = 5
);
  import cnt_pkg::*;

  logic                          enable;
  logic                          nLoad;
  logic                          up;
  logic                          mode;
  logic [DIGIT_W*digits_p-1:0]   loadVal;
  logic [DIGIT_W*digits_p-1:0]   count;
  logic                          tick;
  logic                          tc;
  logic                          ovf;

  // Driver side: issues controls and load data, observes the count.
  modport master (
    output enable, nLoad, up, mode, loadVal,
    input  count, tick, tc, ovf
  );

  // Counter side: receives controls, presents count and status.
  modport slave (
    input  enable, nLoad, up, mode, loadVal,
    output count, tick, tc, ovf
  );
endinterface

// File: rtl/cnt_ndigits_digit.sv
// One radix-base_p digit of the counter. Steps by one when inc is high,
// wrapping at the radix boundary, and reports whether it sits at the
// terminal value for the current direction so the next digit can ripple.
module cnt_digit
  import cnt_pkg::*;
#(
  parameter int base_p = 10
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               load,
  input  logic [DIGIT_W-1:0] loadVal,
  input  logic               inc,
  input  logic               up,
  output logic [DIGIT_W-1:0] value,
  output logic               terminal
);

  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(base_p - 1);

  logic [DIGIT_W-1:0] value_q;
  logic [DIGIT_W-1:0] value_d;

  // Next digit value: load beats increment, increment wraps at the radix.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = clamp_digit(loadVal, MAX_DIGIT);
    end else if (inc) begin
      if (up) begin
        value_d = (value_q == MAX_DIGIT) ? '0 : value_q + 1'b1;
      end else begin
        value_d = (value_q == '0) ? MAX_DIGIT : value_q - 1'b1;
      end
    end
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value    = value_q;
  assign terminal = up ? (value_q == MAX_DIGIT) : (value_q == '0);

endmodule

// File: rtl/cnt_ndigits.sv
// Multi-digit up/down counter advanced by a free-running prescaler.
// Each prescaler wrap is one update event: the digit chain steps once
// (ripple carry/borrow in a single cycle), tick_o pulses, and ovf_o pulses
// if the count was already terminal. In saturate mode a terminal count holds.
module cnt_ndigits
  import cnt_pkg::*;
#(
  parameter int freq_p           = 50000000,
  parameter int update_per_sec_p = 1,
  parameter int base_p           = 10,
  parameter int digits_p         = 5
) (
  input  logic                        clk_i,
  input  logic                        nRst_i,
  input  logic                        enable_i,
  input  logic                        nLoad_i,
  input  logic                        up_i,
  input  logic                        mode_i,
  input  logic [DIGIT_W*digits_p-1:0] loadVal_i,
  output logic [DIGIT_W*digits_p-1:0] count_o,
  output logic                        tick_o,
  output logic                        tc_o,
  output logic                        ovf_o
);

  localparam int PRESC = freq_p / update_per_sec_p;
  // A prescale of 1 still needs a one-bit register.
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0]       presc_q;
  logic [PW-1:0]       presc_d;
  logic                tick_q;
  logic                tick_d;
  logic                ovf_q;
  logic                ovf_d;

  logic                load;
  logic                tick_evt;
  logic                sat_hold;
  logic                advance;
  logic [digits_p-1:0] digit_term;
  logic [digits_p-1:0] carry;

  // Update event detection, saturation gating and prescaler next state.
  always_comb begin
    load     = !nLoad_i;
    // A load on the prescaler's last cycle swallows that update.
    tick_evt = enable_i && (presc_q == PRESC_LAST) && !load;
    sat_hold = tc_o && (mode_i == MODE_SAT);
    advance  = tick_evt && !sat_hold;
    tick_d   = tick_evt;
    ovf_d    = tick_evt && tc_o;

    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (enable_i) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  // Prescaler and registered event pulses; reset outranks everything.
  always_ff @(posedge clk_i) begin
    if (!nRst_i) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
    end
  end

  // Digit k steps only when every lower digit is terminal, so a whole run
  // of terminal digits rolls over in the same cycle.
  for (genvar gi = 0; gi < digits_p; gi++) begin : g_digit
    if (gi == 0) begin : g_first
      assign carry[gi] = advance;
    end else begin : g_rest
      assign carry[gi] = advance && (&digit_term[gi-1:0]);
    end

    cnt_digit #(
      .base_p (base_p)
    ) u_digit (
      .clk      (clk_i),
      .nRst     (nRst_i),
      .load     (load),
      .loadVal  (loadVal_i[gi*DIGIT_W +: DIGIT_W]),
      .inc      (carry[gi]),
      .up       (up_i),
      .value    (count_o[gi*DIGIT_W +: DIGIT_W]),
      .terminal (digit_term[gi])
    );
  end

  assign tc_o   = &digit_term;
  assign tick_o = tick_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_cnt_ndigits.sv
// Directed bench for cnt_ndigits (freq 4 Hz, 1 update/s, base 10, 3 digits).
// An integer reference model predicts each cycle; predictions are queued
// when stimulus is applied and popped against the DUT after the edge.
module tb_cnt_ndigits;

  localparam int FREQ   = 4;
  localparam int UPS    = 1;
  localparam int BASE   = 10;
  localparam int DIGITS = 3;
  localparam int PRESC  = FREQ / UPS;
  localparam int MODULO = BASE ** DIGITS;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  cnt_ndigits_if #(.digits_p(DIGITS)) bus ();

  cnt_ndigits #(
    .freq_p           (FREQ),
    .update_per_sec_p (UPS),
    .base_p           (BASE),
    .digits_p         (DIGITS)
  ) dut (
    .clk_i     (clk),
    .nRst_i    (nrst),
    .enable_i  (bus.enable),
    .nLoad_i   (bus.nLoad),
    .up_i      (bus.up),
    .mode_i    (bus.mode),
    .loadVal_i (bus.loadVal),
    .count_o   (bus.count),
    .tick_o    (bus.tick),
    .tc_o      (bus.tc),
    .ovf_o     (bus.ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [11:0] cnt;
    logic        tick;
    logic        tc;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_steps  = 0;

  // Reference model state: count as a plain integer.
  int m_cnt   = 0;
  int m_presc = 0;
  bit m_tick  = 1'b0;
  bit m_ovf   = 1'b0;

  logic [11:0] tick_mask;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit model_tc(input int v, input bit up);
    return up ? (v == MODULO - 1) : (v == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input bit rst_n, input bit en, input bit nld, input bit up,
                      input bit md, input logic [11:0] lv, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    int   w;
    bit   ev;
    bit   tc_now;

    nrst        = rst_n;
    bus.enable  = en;
    bus.nLoad   = nld;
    bus.up      = up;
    bus.mode    = md;
    bus.loadVal = lv;

    tc_now = model_tc(m_cnt, up);
    if (!rst_n) begin
      m_cnt = 0; m_presc = 0; m_tick = 0; m_ovf = 0;
    end else if (!nld) begin
      m_cnt = 0;
      w = 1;
      for (int i = 0; i < DIGITS; i++) begin
        n = int'(lv[4*i +: 4]);
        if (n > BASE - 1) n = BASE - 1;
        m_cnt += n * w;
        w *= BASE;
      end
      m_presc = 0; m_tick = 0; m_ovf = 0;
    end else begin
      ev = en && (m_presc == PRESC - 1);
      if (en) m_presc = (m_presc + 1) % PRESC;
      m_tick = ev;
      m_ovf  = ev && tc_now;
      if (ev && !(tc_now && md)) begin
        m_cnt = up ? (m_cnt + 1) % MODULO : (m_cnt + MODULO - 1) % MODULO;
      end
    end

    e.tag  = tag;
    e.cnt  = to_bcd(m_cnt);
    e.tick = m_tick;
    e.ovf  = m_ovf;
    e.tc   = model_tc(m_cnt, up);
    sb_q.push_back(e);

    @(posedge clk);
    @(negedge clk);

    n_steps++;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      $display("step %0d %s: count=%h tick=%b tc=%b ovf=%b", n_steps, got.tag,
               bus.count, bus.tick, bus.tc, bus.ovf);
      chk({got.tag, "_count"}, 32'(bus.count), 32'(got.cnt));
      chk({got.tag, "_tick"},  32'(bus.tick),  32'(got.tick));
      chk({got.tag, "_tc"},    32'(bus.tc),    32'(got.tc));
      chk({got.tag, "_ovf"},   32'(bus.ovf),   32'(got.ovf));
    end
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.nLoad   = 1'b1;
    bus.up      = 1'b1;
    bus.mode    = 1'b0;
    bus.loadVal = '0;
    @(negedge clk);

    // Reset state.
    step(0, 1, 0, 1, 0, 12'h555, "reset");
    step(0, 0, 1, 1, 0, 12'h000, "reset");
    chk("reset_count", 32'(bus.count), 32'h000);

    // Count up from zero: ticks after edges 4, 8 and 12.
    tick_mask = '0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 1, 1, 0, 12'h000, "up_run");
      tick_mask[i] = bus.tick;
    end
    chk("up_run_final", 32'(bus.count), 32'h003);
    chk("up_run_ticks", 32'(tick_mask), 32'h888);

    // Up wrap through 999 -> 000 with overflow.
    step(1, 0, 0, 1, 0, 12'h998, "load998");
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 1, 0, 12'h000, "up_wrap");
      if (i == 3) begin
        chk("up_wrap_999", 32'(bus.count), 32'h999);
        chk("up_wrap_tc",  32'(bus.tc),    32'h1);
      end
    end
    chk("up_wrap_000", 32'(bus.count), 32'h000);
    chk("up_wrap_ovf", 32'(bus.ovf),   32'h1);

    // Down with saturation: 001 -> 000, then held with overflow pulses.
    step(1, 0, 0, 0, 1, 12'h001, "load001");
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 1, 0, 1, 12'h000, "down_sat");
      if (i == 3) chk("down_sat_ovf_t1", 32'(bus.ovf), 32'h0);
    end
    chk("down_sat_held", 32'(bus.count), 32'h000);
    chk("down_sat_ovf_t3", 32'(bus.ovf), 32'h1);

    // Down wrap 000 -> 999, then tc follows up_i in the same cycle.
    step(1, 0, 0, 0, 0, 12'h000, "load000");
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 12'h000, "down_wrap");
    chk("down_wrap_999", 32'(bus.count), 32'h999);
    step(1, 0, 1, 1, 0, 12'h000, "dir_up");
    step(1, 0, 1, 0, 0, 12'h000, "dir_down");

    // Clamped load, then a long disabled stretch.
    step(1, 0, 0, 1, 0, 12'hFA5, "loadFA5");
    chk("clamp", 32'(bus.count), 32'h995);
    tick_mask = '0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 1, 1, 0, 12'h000, "disabled");
      tick_mask[0] = tick_mask[0] | bus.tick;
    end
    chk("disabled_count", 32'(bus.count), 32'h995);
    chk("disabled_tick",  32'(tick_mask[0]), 32'h0);

    // Load on the prescaler terminal cycle suppresses the tick.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 12'h000, "pre_load");
    step(1, 1, 0, 1, 0, 12'h123, "load_on_term");
    chk("load_on_term_tick", 32'(bus.tick), 32'h0);

    // Reset two cycles into a period discards the partial prescale.
    for (int i = 0; i < 2; i++) step(1, 1, 1, 1, 0, 12'h000, "pre_rst");
    step(0, 1, 1, 1, 0, 12'h000, "mid_rst");
    chk("mid_rst_count", 32'(bus.count), 32'h000);
    tick_mask = '0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 1, 0, 12'h000, "post_rst");
      tick_mask[i] = bus.tick;
    end
    chk("post_rst_ticks", 32'(tick_mask[3:0]), 32'h8);
    chk("post_rst_count", 32'(bus.count), 32'h001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
